// File: rtl/serial_cmp_ctrl_if.sv
// Request/result bundle for the bit-serial L/G/E comparator sequencer.
// master = requesting block, slave = serial_cmp_ctrl.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             l;
  logic             g;
  logic             e;

  modport master (
    output start, a, b,
    input  busy, done, l, g, e
  );

  modport slave (
    input  start, a, b,
    output busy, done, l, g, e
  );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial MSB-first unsigned L/G/E comparator sequencer (IDLE/RUN/FIN).
// Optional: define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_cmp_ctrl_if.slave bus
);
  localparam int IW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             dl_q, dl_d;
  logic             dg_q, dg_d;
  logic             l_q, l_d;
  logic             g_q, g_d;
  logic             e_q, e_d;
  logic             lt, gt, hit;
  logic             last;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    idx_d   = idx_q;
    dl_d    = dl_q;
    dg_d    = dg_q;
    l_d     = l_q;
    g_d     = g_q;
    e_d     = e_q;
    lt      = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];
    gt      = sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
    // only the first differing bit may set the sticky flags
    hit     = ~(dl_q | dg_q) & (lt | gt);
    last    = (idx_q == '0);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          idx_d   = IW'(WIDTH - 1);
          dl_d    = 1'b0;
          dg_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hit) begin
          dl_d = lt;
          dg_d = gt;
        end
        sa_d = sa_q << 1;
        sb_d = sb_q << 1;
        if (!last)
          idx_d = idx_q - IW'(1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (last || hit) begin
`else
        if (last) begin
`endif
          state_d = FIN;
          l_d     = dl_d;
          g_d     = dg_d;
          e_d     = ~(dl_d | dg_d);
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      idx_q   <= '0;
      dl_q    <= 1'b0;
      dg_q    <= 1'b0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      idx_q   <= idx_d;
      dl_q    <= dl_d;
      dg_q    <= dg_d;
      l_q     <= l_d;
      g_q     <= g_d;
      e_q     <= e_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FIN);
  assign bus.l    = l_q;
  assign bus.g    = g_q;
  assign bus.e    = e_q;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl: WIDTH=8 and WIDTH=1 instances.
// Latency expectations follow SERIAL_CMP_EARLY_EXIT_EN when defined.
module tb_serial_cmp_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_MSB = 1;
  localparam int LAT_B1  = 7;
`else
  localparam int LAT_MSB = 8;
  localparam int LAT_B1  = 8;
`endif

  serial_cmp_ctrl_if #(.WIDTH(8)) m ();
  serial_cmp_ctrl_if #(.WIDTH(1)) s ();

  serial_cmp_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  serial_cmp_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string tag, input logic [7:0] av,
                      input logic [7:0] bv, input logic el,
                      input logic eg, input logic ee, input int lat);
    int n;
    m.start = 1'b1;
    m.a     = av;
    m.b     = bv;
    tick();
    m.start = 1'b0;
    check({tag, "_busy"}, {31'd0, m.busy}, 32'd1);
    n = 0;
    while (!m.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_l"}, {31'd0, m.l}, {31'd0, el});
    check({tag, "_g"}, {31'd0, m.g}, {31'd0, eg});
    check({tag, "_e"}, {31'd0, m.e}, {31'd0, ee});
    check({tag, "_fbusy"}, {31'd0, m.busy}, 32'd0);
    tick();
    check({tag, "_dlow"}, {31'd0, m.done}, 32'd0);
  endtask

  task automatic run1(input string tag, input logic av, input logic bv,
                      input logic el, input logic eg, input logic ee);
    int n;
    s.start = 1'b1;
    s.a     = av;
    s.b     = bv;
    tick();
    s.start = 1'b0;
    check({tag, "_busy"}, {31'd0, s.busy}, 32'd1);
    n = 0;
    while (!s.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 32'd1);
    check({tag, "_l"}, {31'd0, s.l}, {31'd0, el});
    check({tag, "_g"}, {31'd0, s.g}, {31'd0, eg});
    check({tag, "_e"}, {31'd0, s.e}, {31'd0, ee});
    tick();
    check({tag, "_dlow"}, {31'd0, s.done}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    m.start = 1'b0;
    m.a     = '0;
    m.b     = '0;
    s.start = 1'b0;
    s.a     = '0;
    s.b     = '0;
    tick();
    tick();
    check("rst_busy", {31'd0, m.busy}, 32'd0);
    check("rst_done", {31'd0, m.done}, 32'd0);
    check("rst_lge", {29'd0, m.l, m.g, m.e}, 32'd0);
    rst_n = 1'b1;
    tick();

    run8("eq", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 8);

    // abort mid-RUN: reset at edge t0+3 must clear result and suppress DONE
    m.start = 1'b1;
    m.a     = 8'h0F;
    m.b     = 8'hF0;
    tick();
    m.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", {31'd0, m.busy}, 32'd0);
    check("abort_done", {31'd0, m.done}, 32'd0);
    check("abort_lge", {29'd0, m.l, m.g, m.e}, 32'd0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m.done) pulses++;
    end
    check("abort_nodone", pulses, 32'd0);

    run8("msb", 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, LAT_MSB);
    run8("lsb", 8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 8);
    run8("lt_msb", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, LAT_MSB);

    // START held high; A changes mid-RUN and is picked up only on restart
    m.start = 1'b1;
    m.a     = 8'h01;
    m.b     = 8'h02;
    tick();
    m.a = 8'hFF;
    n   = 0;
    while (!m.done && n < 40) begin
      tick();
      n++;
    end
    check("hold_lat1", n, LAT_B1);
    check("hold_l1", {29'd0, m.l, m.g, m.e}, 32'd4);
    tick();
    check("hold_pulse", {31'd0, m.done}, 32'd0);
    n = 1;
    while (!m.done && n < 40) begin
      tick();
      n++;
    end
    check("hold_gap", n, 2 + LAT_MSB);
    check("hold_g2", {29'd0, m.l, m.g, m.e}, 32'd2);
    m.start = 1'b0;
    tick();
    check("hold_idle", {30'd0, m.busy, m.done}, 32'd0);

    run1("w1_lt", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run1("w1_eq", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run1("w1_gt", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
